gpio_rmw_ctrl: RTL and testbench

//  Wishbone master that sequences atomic bit operations on the gpio_top register file.

---
 rtl/gpio_rmw_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_gpio_rmw_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_rmw_ctrl.sv
// gpio_rmw_ctrl: Wishbone master that runs atomic READ / WRITE / SET / CLR / TGL
// commands against the gpio_top register file on behalf of NUM_REQ requesters.
// A round-robin arbiter picks one command at a time. SET/CLR/TGL are done as a
// read followed by a write with cyc held high throughout, so the RMW is locked.
//
// Request handshake: a requester raises req_valid_i[n] with op/reg/mask and holds
// all of them stable until it sees req_ready_o[n]=1. The command is accepted on
// the clock edge that ends the ready cycle; ready is one-hot and is only ever
// raised in IDLE. Each accepted command gets exactly one one-cycle rsp_valid_o
// pulse, unless a reset aborts it.
module gpio_rmw_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [3*NUM_REQ-1:0] req_op_i,
  input  logic [2*NUM_REQ-1:0] req_reg_i,
  input  logic [32*NUM_REQ-1:0] req_mask_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 rsp_valid_o,
  output logic [2:0]           rsp_id_o,
  output logic                 rsp_err_o,
  output logic [31:0]          rsp_data_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [AW-1:0]        wbm_adr_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i
);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_TGL   = 3'd4;

  // Timeout counter counts 0..TIMEOUT-1 cycles of an unacknowledged access.
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  state_t          state_q;
  logic [2:0]      ptr_q;
  logic [2:0]      id_q;
  logic [2:0]      op_q;
  logic [1:0]      reg_q;
  logic [31:0]     mask_q;
  logic [31:0]     old_q;
  logic [31:0]     data_q;
  logic            err_q;
  logic [TW-1:0]   tmo_q;

  logic            gnt_any;
  logic [2:0]      gnt_idx;
  logic [2:0]      gnt_op;
  logic [1:0]      gnt_reg;
  logic [31:0]     gnt_mask;
  logic            gnt_bad;
  logic [31:0]     wdat_d;
  logic            tmo_hit;
  logic            bus_act;

  // Round-robin pick: first valid requester above the pointer, else the lowest valid one.
  always_comb begin
    logic       hit_hi;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    hit_hi  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit_hi && req_valid_i[i] && (3'(i) > ptr_q)) begin
        hit_hi = 1'b1;
        hi_idx = 3'(i);
      end
      if (!gnt_any && req_valid_i[i]) begin
        gnt_any = 1'b1;
        lo_idx  = 3'(i);
      end
    end
    gnt_idx = hit_hi ? hi_idx : lo_idx;
  end

  // Select the granted requester's command fields.
  always_comb begin
    gnt_op   = '0;
    gnt_reg  = '0;
    gnt_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == gnt_idx) begin
        gnt_op   = req_op_i[i*3 +: 3];
        gnt_reg  = req_reg_i[i*2 +: 2];
        gnt_mask = req_mask_i[i*32 +: 32];
      end
    end
    // IN is read-only; ops 5..7 are undefined.
    gnt_bad = (gnt_op > OP_TGL) || ((gnt_reg == 2'd0) && (gnt_op != OP_READ));
  end

  // Value driven during the write phase.
  always_comb begin
    case (op_q)
      OP_SET:  wdat_d = old_q | mask_q;
      OP_CLR:  wdat_d = old_q & ~mask_q;
      OP_TGL:  wdat_d = old_q ^ mask_q;
      default: wdat_d = mask_q;
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TMO_LAST));
  assign bus_act = (state_q == S_RD) || (state_q == S_WR);

  // Command sequencer: arbitration, bus phases, error/timeout handling and response capture.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'(NUM_REQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      reg_q   <= '0;
      mask_q  <= '0;
      old_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            ptr_q  <= gnt_idx;
            id_q   <= gnt_idx;
            op_q   <= gnt_op;
            reg_q  <= gnt_reg;
            mask_q <= gnt_mask;
            tmo_q  <= '0;
            data_q <= '0;
            err_q  <= gnt_bad;
            if (gnt_bad)                 state_q <= S_RSP;
            else if (gnt_op == OP_WRITE) state_q <= S_WR;
            else                         state_q <= S_RD;
          end
        end
        S_RD: begin
          if (wbm_err_i || (!wbm_ack_i && tmo_hit)) begin
            err_q   <= 1'b1;
            data_q  <= '0;
            state_q <= S_RSP;
          end else if (wbm_ack_i) begin
            old_q <= wbm_dat_i;
            tmo_q <= '0;
            if (op_q == OP_READ) begin
              data_q  <= wbm_dat_i;
              state_q <= S_RSP;
            end else begin
              state_q <= S_WR;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WR: begin
          if (wbm_err_i || (!wbm_ack_i && tmo_hit)) begin
            err_q   <= 1'b1;
            data_q  <= '0;
            state_q <= S_RSP;
          end else if (wbm_ack_i) begin
            data_q  <= wdat_d;
            state_q <= S_RSP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RSP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = ((state_q == S_IDLE) && gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign wbm_cyc_o   = bus_act;
  assign wbm_stb_o   = bus_act;
  assign wbm_we_o    = (state_q == S_WR);
  assign wbm_adr_o   = bus_act ? (AW'(reg_q) << 2) : '0;
  assign wbm_sel_o   = bus_act ? 4'hF : 4'h0;
  assign wbm_dat_o   = (state_q == S_WR) ? wdat_d : '0;
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_id_o    = (state_q == S_RSP) ? id_q : '0;
  assign rsp_err_o   = (state_q == S_RSP) ? err_q : 1'b0;
  assign rsp_data_o  = (state_q == S_RSP) ? data_q : '0;

endmodule

// File: tb/tb_gpio_rmw_ctrl.sv
// Bench for gpio_rmw_ctrl: Wishbone slave model of the gpio register file with
// scripted wait/error/hang behaviour, a command-level reference model that
// predicts grant order, responses and latency, and a monitor that pops and checks.
module tb_gpio_rmw_ctrl;
  localparam int N   = 4;
  localparam int AW  = 4;
  localparam int TMO = 16;
  localparam int W   = 44; // {latency[7:0], err, id[2:0], data[31:0]}

  typedef struct packed {
    logic [1:0] kind;  // 0 ack, 1 err, 2 never answer, 3 ack+err
    logic [1:0] waits;
  } plan_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [3*N-1:0]    req_op;
  logic [2*N-1:0]    req_reg;
  logic [32*N-1:0]   req_mask;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic              rsp_err;
  logic [31:0]       rsp_data;
  logic              cyc, stb, we;
  logic [AW-1:0]     adr;
  logic [3:0]        sel;
  logic [31:0]       dat_o;
  logic [31:0]       dat_i;
  logic              wb_ack = 1'b0;
  logic              wb_err = 1'b0;

  logic [2:0]  cmd_op[N];
  logic [1:0]  cmd_reg[N];
  logic [31:0] cmd_mask[N];

  logic [W-1:0] exp_q[$];
  logic [2:0]   gnt_q[$];
  plan_t        plan_q[$];

  logic [31:0] mem[4];   // slave register contents
  logic [31:0] mdl[4];   // reference model register contents
  logic [31:0] gpio_in = 32'hA5A5_0000;
  int rr_m = N - 1;
  int plan_mode = 0;     // 0 random, 1 zero-wait ack, 2 never answer
  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int acc_cyc[8];
  int last_rsp_cyc = 0;
  bit check_b2b = 1'b0;
  bit b2b_armed = 1'b0;

  gpio_rmw_ctrl #(.NUM_REQ(N), .AW(AW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_reg_i(req_reg), .req_mask_i(req_mask),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_sel_o(sel),
    .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(wb_ack), .wbm_err_i(wb_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op[i*3 +: 3]     = cmd_op[i];
      req_reg[i*2 +: 2]    = cmd_reg[i];
      req_mask[i*32 +: 32] = cmd_mask[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Wishbone slave ----------------
  assign dat_i = (adr[3:2] == 2'd0) ? gpio_in : mem[adr[3:2]];

  plan_t       cur;
  bit          have_plan = 1'b0;
  bit          prev_done = 1'b0;
  bit          p_wr = 1'b0;
  logic [1:0]  p_idx;
  logic [31:0] p_dat;
  int          cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      have_plan = 1'b0; prev_done = 1'b0; cnt = 0;
      wb_ack = 1'b0; wb_err = 1'b0;
    end else begin
      if (prev_done) begin
        if (p_wr) mem[p_idx] = p_dat;
        have_plan = 1'b0;
        cnt = 0;
      end else if (have_plan) begin
        cnt++;
      end
      if (!stb) have_plan = 1'b0;
      if (stb && !have_plan) begin
        have_plan = 1'b1;
        cnt = 0;
        tests++;
        if (plan_q.size() == 0) begin
          fails++;
          $display("FAIL bus_access: unplanned access adr=%h we=%b", adr, we);
          cur.kind = 2'd2; cur.waits = 2'd0;
        end else begin
          cur = plan_q.pop_front();
        end
      end
      wb_ack = stb && have_plan && (cnt == int'(cur.waits)) && (cur.kind == 2'd0 || cur.kind == 2'd3);
      wb_err = stb && have_plan && (cnt == int'(cur.waits)) && (cur.kind == 2'd1 || cur.kind == 2'd3);
      prev_done = wb_ack || wb_err;
      p_wr  = we && wb_ack && !wb_err;
      p_idx = adr[3:2];
      p_dat = dat_o;
    end
  end

  // ---------------- reference model ----------------
  task automatic model_access(output bit ok, output int c);
    plan_t p;
    int r;
    p.waits = 2'd0;
    p.kind  = 2'd0;
    if (plan_mode == 2) p.kind = 2'd2;
    else if (plan_mode == 0) begin
      r = $urandom_range(0, 9);
      p.waits = 2'($urandom_range(0, 3));
      p.kind  = (r < 7) ? 2'd0 : 2'(r - 6);
    end
    plan_q.push_back(p);
    ok = (p.kind == 2'd0);
    c  = (p.kind == 2'd2) ? TMO : int'(p.waits) + 1;
  endtask

  task automatic model_cmd(input int id);
    int op, rg, lat, c;
    bit ok, e;
    logic [31:0] m, old, nv, data;
    op = cmd_op[id]; rg = cmd_reg[id]; m = cmd_mask[id];
    lat = 1; e = 1'b0; data = '0; nv = '0;
    if (op > 4 || (rg == 0 && op != 0)) e = 1'b1;
    else if (op == 1) begin
      model_access(ok, c); lat += c;
      if (ok) begin mdl[rg] = m; data = m; end else e = 1'b1;
    end else begin
      model_access(ok, c); lat += c;
      if (!ok) e = 1'b1;
      else begin
        old = (rg == 0) ? gpio_in : mdl[rg];
        if (op == 0) data = old;
        else begin
          case (op)
            2: nv = old | m;
            3: nv = old & ~m;
            default: nv = old ^ m;
          endcase
          model_access(ok, c); lat += c;
          if (ok) begin mdl[rg] = nv; data = nv; end else e = 1'b1;
        end
      end
    end
    exp_q.push_back({lat[7:0], e, id[2:0], data});
    gnt_q.push_back(id[2:0]);
  endtask

  // ---------------- driver ----------------
  task automatic set_cmd(input int id, input int op, input int rg, input logic [31:0] m);
    cmd_op[id] = 3'(op); cmd_reg[id] = 2'(rg); cmd_mask[id] = m;
  endtask

  task automatic run_batch(input logic [N-1:0] set);
    logic [N-1:0] pend, g;
    int n;
    pend = set;
    while (pend != 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (rr_m + k) % N;
        if (pend[idx]) begin
          model_cmd(idx);
          pend[idx] = 1'b0;
          rr_m = idx;
          break;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = set;
    n = 0;
    while (req_valid != 0 && n < 2000) begin
      @(negedge clk); n++;
      g = req_ready;
      if (g != 0) begin
        @(posedge clk); #1;
        req_valid = req_valid & ~g;
      end
    end
    check("all_granted", 64'(req_valid), 64'd0);
    req_valid = '0;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    check("rsp_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("plan_used", 64'(plan_q.size()), 64'd0);
    exp_q.delete(); gnt_q.delete(); plan_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    int gid, lat;
    logic [W-1:0] got, e;
    if (!rst) begin
      if (req_ready != 0) begin
        gid = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        check("ready_onehot", 64'($countones(req_ready)), 64'd1);
        if (gnt_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL grant: unexpected grant %b", req_ready);
        end else begin
          check("grant_id", 64'(gid), 64'(gnt_q.pop_front()));
        end
        acc_cyc[gid] = cyc_cnt;
        if (check_b2b && b2b_armed) check("b2b_gap", 64'(cyc_cnt - last_rsp_cyc), 64'd1);
        b2b_armed = 1'b0;
      end
      if (rsp_valid) begin
        lat = cyc_cnt - acc_cyc[rsp_id];
        got = {lat[7:0], rsp_err, rsp_id, rsp_data};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rsp: unexpected response id=%0d err=%0b data=%h", rsp_id, rsp_err, rsp_data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL rsp: got id=%0d err=%0b data=%h lat=%0d, expected id=%0d err=%0b data=%h lat=%0d",
                     rsp_id, rsp_err, rsp_data, lat, e[34:32], e[35], e[31:0], e[43:36]);
          end
        end
        last_rsp_cyc = cyc_cnt;
        b2b_armed = 1'b1;
      end
      if (stb || cyc) check("bus_ctrl", {cyc, stb, sel}, {1'b1, 1'b1, 4'hF});
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin mem[i] = '0; mdl[i] = '0; end
    for (int i = 0; i < N; i++) set_cmd(i, 0, 0, 32'd0);
    for (int i = 0; i < 8; i++) acc_cyc[i] = 0;
    @(negedge clk);
    check("reset_rsp", {req_ready, rsp_valid, rsp_id, rsp_err, rsp_data}, 64'd0);
    check("reset_bus", {cyc, stb, we, adr, sel, dat_o}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Round-robin: four TGL OE mask 1 -> grants 0,1,2,3, OE back to 0.
    plan_mode = 1;
    for (int i = 0; i < N; i++) set_cmd(i, 4, 2, 32'h1);
    run_batch(4'hF);
    check("oe_final", mem[2], 32'h0);

    // SET on OUT=0xF0 with mask 0x0F.
    set_cmd(0, 1, 1, 32'h0000_00F0); run_batch(4'b0001);
    set_cmd(0, 2, 1, 32'h0000_000F); run_batch(4'b0001);
    check("set_result", mem[1], 32'h0000_00FF);

    // Illegal: CLR on IN, and op 6.
    set_cmd(2, 3, 0, 32'hFFFF_FFFF); set_cmd(1, 6, 1, 32'h1);
    run_batch(4'b0110);

    // Timeout on a READ.
    plan_mode = 2;
    set_cmd(0, 0, 1, 32'h0); run_batch(4'b0001);

    // Back-to-back READ IN.
    plan_mode = 1;
    gpio_in = 32'h0000_1234;
    set_cmd(1, 0, 0, 32'h0); set_cmd(2, 0, 0, 32'h0);
    check_b2b = 1'b1; b2b_armed = 1'b0;
    run_batch(4'b0110);
    check_b2b = 1'b0;

    // Reset during the write phase of a SET.
    set_cmd(0, 2, 1, 32'h0000_0F00);
    plan_q.push_back(plan_t'{kind: 2'd0, waits: 2'd0});
    plan_q.push_back(plan_t'{kind: 2'd2, waits: 2'd0});
    gnt_q.push_back(3'd0);
    @(posedge clk); #1; req_valid = 4'b0001;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1; req_valid = '0;
    n = 0;
    while (!we && n < 50) begin @(negedge clk); n++; end
    check("we_before_reset", 64'(we), 64'd1);
    rst = 1'b1; #1;
    check("reset_bus_drop", {cyc, stb, we, sel, rsp_valid}, 64'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    rr_m = N - 1;
    gnt_q.delete(); plan_q.delete();
    repeat (4) @(negedge clk);
    check("no_torn_write", mem[1], mdl[1]);
    for (int i = 0; i < N; i++) set_cmd(i, 0, 1, 32'h0);
    run_batch(4'hF);

    // Randomized batches.
    plan_mode = 0;
    repeat (40) begin
      gpio_in = $urandom;
      for (int i = 0; i < N; i++) begin
        logic [2:0] op;
        op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        set_cmd(i, int'(op), $urandom_range(0, 3), $urandom);
      end
      run_batch(N'($urandom_range(1, 15)));
    end
    for (int i = 1; i < 4; i++) check("final_reg", mem[i], mdl[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
